// File: rtl/ncl_steer_pkg.sv
// rtl/ncl_steer_pkg.sv - shared types and constants for the clocked-to-NCL steer source
package ncl_steer_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        NULL_W = 2'd2
    } state_t;

    // Dual-rail encodings: bit 1 is the TRUE rail, bit 0 the FALSE rail.
    localparam logic [1:0] DR_NULL  = 2'b00;
    localparam logic [1:0] DR_FALSE = 2'b01;
    localparam logic [1:0] DR_TRUE  = 2'b10;

    // Steer destinations, in binary as presented on in_sel.
    localparam logic [1:0] S = 2'd0;
    localparam logic [1:0] T = 2'd1;
    localparam logic [1:0] U = 2'd2;
    localparam logic [1:0] V = 2'd3;

    function automatic logic [1:0] dr_encode(input logic b);
        return b ? DR_TRUE : DR_FALSE;
    endfunction

    function automatic logic [3:0] steer_onehot(input logic [1:0] sel);
        logic [3:0] oh;
        oh = 4'b0000;
        case (sel)
            S: oh = 4'b0001;
            T: oh = 4'b0010;
            U: oh = 4'b0100;
            V: oh = 4'b1000;
        endcase
        return oh;
    endfunction

endpackage

// File: rtl/ncl_comp_sync.sv
// rtl/ncl_comp_sync.sv - flop-chain synchronizer for an asynchronous NCL completion signal
module ncl_comp_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic init,
    input  logic din,
    output logic dout
);

    logic [SYNC_STAGES-1:0] chain;

    // Shift the completion level through the chain; init clears it to the NULL level.
    always_ff @(posedge clk or posedge init) begin
        if (init) begin
            chain <= '0;
        end else begin
            chain <= {chain[SYNC_STAGES-2:0], din};
        end
    end

    assign dout = chain[SYNC_STAGES-1];

endmodule

// File: rtl/steer_sync_src.sv
// rtl/steer_sync_src.sv - valid/ready token source driving DATA/NULL wavefronts into the 4-way steer
module steer_sync_src
    import ncl_steer_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int CNT_W          = 16
) (
    input  logic             clk,
    input  logic             init,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_sel,
    input  logic             in_bit,
    output logic [1:0]       A,
    input  logic             ACOMP,
    output logic [3:0]       steerin,
    input  logic             steerinCOMP,
    output logic             busy,
    output logic             err,
    output logic [CNT_W-1:0] xfer_count
);

    localparam int WAIT_W = $clog2(TIMEOUT_CYCLES + 1);

    state_t            state;
    state_t            state_nxt;
    logic              sync_a;
    logic              sync_s;
    logic              ack_data;
    logic              ack_null;
    logic              buf_full;
    logic [1:0]        buf_sel;
    logic              buf_bit;
    logic              accept;
    logic              issue;
    logic              cnt_inc;
    logic [1:0]        a_nxt;
    logic [3:0]        steer_nxt;
    logic [WAIT_W-1:0] wait_cnt;

    ncl_comp_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_a (
        .clk  (clk),
        .init (init),
        .din  (ACOMP),
        .dout (sync_a)
    );

    ncl_comp_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_s (
        .clk  (clk),
        .init (init),
        .din  (steerinCOMP),
        .dout (sync_s)
    );

    // A mismatched pair of completions is neither ack, so the FSM simply holds.
    assign ack_data = sync_a & sync_s;
    assign ack_null = ~sync_a & ~sync_s;

    assign in_ready = ~buf_full;
    assign accept   = in_valid & in_ready;
    assign busy     = (state != IDLE);

    // Next-state and next-wavefront selection; the buffered token is older, so it wins.
    always_comb begin
        state_nxt = state;
        a_nxt     = A;
        steer_nxt = steerin;
        issue     = 1'b0;
        cnt_inc   = 1'b0;
        case (state)
            IDLE: begin
                if (ack_null && (buf_full || accept)) begin
                    issue     = 1'b1;
                    state_nxt = DATA;
                    if (buf_full) begin
                        a_nxt     = dr_encode(buf_bit);
                        steer_nxt = steer_onehot(buf_sel);
                    end else begin
                        a_nxt     = dr_encode(in_bit);
                        steer_nxt = steer_onehot(in_sel);
                    end
                end
            end
            DATA: begin
                if (ack_data) begin
                    state_nxt = NULL_W;
                    a_nxt     = DR_NULL;
                    steer_nxt = 4'b0000;
                end
            end
            NULL_W: begin
                if (ack_null) begin
                    state_nxt = IDLE;
                    cnt_inc   = 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
                a_nxt     = DR_NULL;
                steer_nxt = 4'b0000;
            end
        endcase
    end

    // State and registered wavefront outputs; init drops both to NULL immediately.
    always_ff @(posedge clk or posedge init) begin
        if (init) begin
            state   <= IDLE;
            A       <= DR_NULL;
            steerin <= 4'b0000;
        end else begin
            state   <= state_nxt;
            A       <= a_nxt;
            steerin <= steer_nxt;
        end
    end

    // One-entry holding buffer: filled by any acceptance not issued straight away.
    always_ff @(posedge clk or posedge init) begin
        if (init) begin
            buf_full <= 1'b0;
            buf_sel  <= 2'd0;
            buf_bit  <= 1'b0;
        end else if (issue && buf_full) begin
            buf_full <= 1'b0;
        end else if (accept && !issue) begin
            buf_full <= 1'b1;
            buf_sel  <= in_sel;
            buf_bit  <= in_bit;
        end
    end

    // Completed DATA+NULL cycles, wrapping at the counter width.
    always_ff @(posedge clk or posedge init) begin
        if (init) begin
            xfer_count <= '0;
        end else if (cnt_inc) begin
            xfer_count <= xfer_count + CNT_W'(1);
        end
    end

    // Wait-state watchdog: flags err once but never abandons the wavefront.
    always_ff @(posedge clk or posedge init) begin
        if (init) begin
            wait_cnt <= '0;
            err      <= 1'b0;
        end else if (state == IDLE || state_nxt != state) begin
            wait_cnt <= '0;
        end else if (wait_cnt != WAIT_W'(TIMEOUT_CYCLES)) begin
            wait_cnt <= wait_cnt + 1'b1;
            if (wait_cnt == WAIT_W'(TIMEOUT_CYCLES - 1)) begin
                err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_steer_sync_src.sv
// tb/tb_steer_sync_src.sv - self-checking bench for steer_sync_src
module tb_steer_sync_src;

    localparam int SYNC = 2;
    localparam int TMO  = 16;
    localparam int CW   = 2;

    logic          clk         = 1'b0;
    logic          init        = 1'b1;
    logic          in_valid    = 1'b0;
    logic [1:0]    in_sel      = 2'd0;
    logic          in_bit      = 1'b0;
    logic          ACOMP       = 1'b0;
    logic          steerinCOMP = 1'b0;
    logic          in_ready;
    logic [1:0]    A;
    logic [3:0]    steerin;
    logic          busy;
    logic          err;
    logic [CW-1:0] xfer_count;

    int checks = 0;
    int errors = 0;
    logic resp_en = 1'b0;

    // Model state
    logic [2:0] acc_q[$];
    logic [5:0] obs_q[$];
    logic [1:0] p_a;
    logic [3:0] p_s;
    logic       p_busy;
    int         m_xfer;
    int         stall;
    logic       m_err;
    int         both_cnt = 0;
    int         none_cnt = 0;

    always #5 clk = ~clk;

    steer_sync_src #(
        .SYNC_STAGES    (SYNC),
        .TIMEOUT_CYCLES (TMO),
        .CNT_W          (CW)
    ) dut (
        .clk         (clk),
        .init        (init),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_sel      (in_sel),
        .in_bit      (in_bit),
        .A           (A),
        .ACOMP       (ACOMP),
        .steerin     (steerin),
        .steerinCOMP (steerinCOMP),
        .busy        (busy),
        .err         (err),
        .xfer_count  (xfer_count)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Acceptances and completion history seen at each rising edge
    always @(posedge clk) begin
        both_cnt <= (ACOMP && steerinCOMP) ? both_cnt + 1 : 0;
        none_cnt <= (!ACOMP && !steerinCOMP) ? none_cnt + 1 : 0;
        if (!init && in_valid && in_ready) acc_q.push_back({in_sel, in_bit});
    end

    // Per-cycle compare against the token-level model
    always @(negedge clk) begin : compare
        logic [2:0] tok;
        int         nx;
        int         ns;
        logic       ne;
        logic       chg;
        if (init) begin
            acc_q.delete();
            obs_q.delete();
            p_a    <= 2'b00;
            p_s    <= 4'b0000;
            p_busy <= 1'b0;
            m_xfer <= 0;
            stall  <= 0;
            m_err  <= 1'b0;
        end else begin
            chk("rails_exclusive", A == 2'b11, 0);
            chk("steer_onehot", $countones(steerin) <= 1, 1);
            chk("null_agree", A == 2'b00, steerin == 4'b0000);
            chk("busy_with_data", busy || (A == 2'b00), 1);
            chg = (A !== p_a) || (steerin !== p_s) || (busy !== p_busy);
            if ((A !== p_a) || (steerin !== p_s)) begin
                if (p_a == 2'b00 && p_s == 4'b0000) begin
                    chk("token_pending", acc_q.size() > 0, 1);
                    chk("entry_from_idle", p_busy, 0);
                    if (acc_q.size() > 0) begin
                        tok = acc_q.pop_front();
                        chk("data_A", A, tok[0] ? 2'b10 : 2'b01);
                        chk("data_steer", steerin, 4'b0001 << tok[2:1]);
                    end
                    obs_q.push_back({A, steerin});
                end else begin
                    chk("data_to_null", {A, steerin}, 6'b000000);
                    chk("null_after_ack", both_cnt >= SYNC + 1, 1);
                end
            end
            nx = m_xfer;
            if (p_busy && !busy) begin
                nx = (m_xfer + 1) % (1 << CW);
                chk("idle_after_ack", none_cnt >= SYNC + 1, 1);
            end
            chk("xfer_count", xfer_count, nx);
            chk("in_ready", in_ready, acc_q.size() == 0);
            ns = chg ? 0 : (busy ? stall + 1 : stall);
            ne = m_err || (busy && ns >= TMO);
            chk("err", err, ne);
            p_a    <= A;
            p_s    <= steerin;
            p_busy <= busy;
            m_xfer <= nx;
            stall  <= ns;
            m_err  <= ne;
        end
    end

    // One cycle; when enabled the bench plays the steer stage's 4-phase completions
    task automatic step();
        @(negedge clk);
        if (resp_en) begin
            ACOMP       = (A != 2'b00);
            steerinCOMP = (A != 2'b00);
        end
    endtask

    task automatic do_init();
        resp_en     = 1'b0;
        ACOMP       = 1'b0;
        steerinCOMP = 1'b0;
        in_valid    = 1'b0;
        step();
        #2 init = 1'b1;
        step();
        #2 init = 1'b0;
    endtask

    // Presents a token and returns on the cycle after it is accepted
    task automatic send(input logic [1:0] sel, input logic b);
        int n = 0;
        in_valid = 1'b1;
        in_sel   = sel;
        in_bit   = b;
        while (!in_ready && n < 200) begin
            step();
            n++;
        end
        chk("send_bound", n < 200, 1);
        step();
        in_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while ((busy || !in_ready) && n < 200) begin
            step();
            n++;
        end
        chk({name, "_idle_bound"}, n < 200, 1);
    endtask

    logic [5:0]    exp_obs [3] = '{6'b01_0001, 6'b10_1000, 6'b01_0010};
    logic [CW-1:0] exp_wrap[5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};

    initial begin
        step();
        #2 init = 1'b0;
        step();
        chk("rst_A", A, 2'b00);
        chk("rst_steer", steerin, 4'b0000);
        chk("rst_ready", in_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_err", err, 0);
        chk("rst_xfer", xfer_count, 0);

        // Basic transfer
        send(2'd2, 1'b1);
        chk("basic_A", A, 2'b10);
        chk("basic_steer", steerin, 4'b0100);
        chk("basic_busy", busy, 1);
        ACOMP = 1'b1; steerinCOMP = 1'b1;
        step(); step();
        chk("basic_hold_A", A, 2'b10);
        step();
        chk("basic_null_A", A, 2'b00);
        chk("basic_null_steer", steerin, 4'b0000);
        ACOMP = 1'b0; steerinCOMP = 1'b0;
        step(); step();
        chk("basic_nullw_busy", busy, 1);
        step();
        chk("basic_done_busy", busy, 0);
        chk("basic_xfer", xfer_count, 1);

        // Back-to-back through the holding buffer
        do_init();
        resp_en = 1'b1;
        send(2'd0, 1'b0);
        send(2'd3, 1'b1);
        chk("b2b_buf_full_ready", in_ready, 0);
        send(2'd1, 1'b0);
        wait_idle("b2b");
        chk("b2b_xfer", xfer_count, 3);
        chk("b2b_obs_count", obs_q.size(), 3);
        for (int i = 0; i < 3 && i < obs_q.size(); i++) chk("b2b_obs", obs_q[i], exp_obs[i]);
        resp_en = 1'b0;
        ACOMP = 1'b0; steerinCOMP = 1'b0;

        // Partial acknowledge
        do_init();
        send(2'd1, 1'b0);
        ACOMP = 1'b1;
        repeat (6) step();
        chk("partial_hold_A", A, 2'b01);
        chk("partial_hold_steer", steerin, 4'b0010);
        chk("partial_busy", busy, 1);
        steerinCOMP = 1'b1;
        step(); step();
        chk("partial_still_A", A, 2'b01);
        step();
        chk("partial_null", {A, steerin}, 6'b000000);
        ACOMP = 1'b0; steerinCOMP = 1'b0;
        repeat (3) step();
        chk("partial_busy_done", busy, 0);
        chk("partial_xfer", xfer_count, 1);

        // Timeout
        do_init();
        send(2'd0, 1'b1);
        repeat (15) step();
        chk("tmo_err_before", err, 0);
        step();
        chk("tmo_err_at", err, 1);
        chk("tmo_A", A, 2'b10);
        chk("tmo_steer", steerin, 4'b0001);
        ACOMP = 1'b1; steerinCOMP = 1'b1;
        repeat (3) step();
        chk("tmo_null", {A, steerin}, 6'b000000);
        ACOMP = 1'b0; steerinCOMP = 1'b0;
        repeat (3) step();
        chk("tmo_busy_done", busy, 0);
        chk("tmo_err_sticky", err, 1);
        chk("tmo_xfer", xfer_count, 1);

        // Reset mid-wavefront, no clock edge needed
        send(2'd3, 1'b1);
        chk("rmid_data", {A, steerin}, 6'b10_1000);
        #2 init = 1'b1;
        #1;
        chk("rmid_A", A, 2'b00);
        chk("rmid_steer", steerin, 4'b0000);
        chk("rmid_ready", in_ready, 1);
        chk("rmid_err", err, 0);
        chk("rmid_xfer", xfer_count, 0);
        chk("rmid_busy", busy, 0);
        step();
        #2 init = 1'b0;

        // Counter wrap
        resp_en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            send(2'(i % 4), 1'(i % 2));
            wait_idle("wrap");
            chk("wrap_xfer", xfer_count, exp_wrap[i]);
        end
        resp_en = 1'b0;
        ACOMP = 1'b0; steerinCOMP = 1'b0;
        repeat (4) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/steer_sync_src.md
Name: steer_sync_src

Overview:
- Clocked-to-NCL bridge that sits directly upstream of the 4-way steer stage.
- Accepts a (destination, data bit) pair on a valid/ready interface.
- Emits one dual-rail data wavefront on A plus a one-hot steer wavefront on steerin, then a NULL wavefront on both.
- Sequences DATA and NULL strictly on the steer stage's completion signals, ACOMP and steerinCOMP, so clocked producers can drive the asynchronous steer fabric safely.

Parameters:
- SYNC_STAGES, 2, flop depth of the completion-input synchronizers (min 2).
- TIMEOUT_CYCLES, 1024, cycles a wait state may last before err is flagged.
- CNT_W, 16, width of the transfer counter.

Ports:
- clk  input  1  single clock.
- init  input  1  asynchronous active-high reset.
- in_valid  input  1  request carries a token.
- in_ready  output  1  block can accept a token this cycle.
- in_sel  input  2  destination, binary: 0=S, 1=T, 2=U, 3=V.
- in_bit  input  1  data value to send.
- A  output  2  dual-rail data to the steer: A[1]=TRUE rail, A[0]=FALSE rail.
- ACOMP  input  1  data completion from the steer (async).
- steerin  output  4  one-hot steer control: bit k selects destination k.
- steerinCOMP  input  1  steer-control completion from the steer (async).
- busy  output  1  a wavefront is in flight.
- err  output  1  sticky timeout flag.
- xfer_count  output  CNT_W  count of completed DATA+NULL cycles.

Behaviour:
- Reset (init=1, async): A=2'b00, steerin=4'b0000 (NULL), in_ready=1, busy=0, err=0, xfer_count=0, holding buffer empty, FSM in IDLE, synchronizer flops cleared to 0. Reset mid-wavefront forces NULL outputs immediately; the downstream stage is re-initialised by its own init.
- All outputs are registered; A and steerin change only on clk rising edges.
- Completion inputs pass through SYNC_STAGES flops (sub-module).
  - ack_data = sync(ACOMP) & sync(steerinCOMP).
  - ack_null = ~sync(ACOMP) & ~sync(steerinCOMP).
- Holding buffer: one entry.
  - in_ready = ~buf_full. A token is accepted when in_valid & in_ready.
  - A token accepted in IDLE bypasses the buffer.
- FSM states: IDLE, DATA, NULL_W.
  - IDLE: if a token is available (accepted this cycle or buffered), load A = in_bit ? 2'b10 : 2'b01, load steerin = 1<<in_sel, go to DATA. Outputs are valid on the cycle after acceptance (latency 1). If ack_null is not yet true on IDLE entry after reset, stay in IDLE.
  - DATA: hold A and steerin stable. On ack_data, drive A=00 and steerin=0000, go to NULL_W.
  - NULL_W: hold NULL. On ack_null, increment xfer_count (wraps modulo 2^CNT_W), go to IDLE.
  - If the buffer holds a token when IDLE is entered, the next DATA is driven on the following cycle.
- NCL rules:
  - Never change A or steerin while in DATA or NULL_W except on the transition out.
  - Never drive both rails of A, nor more than one steerin bit.
- busy = (state != IDLE).
- Timeout: a wait counter counts cycles in DATA or NULL_W and resets on state change. When it reaches TIMEOUT_CYCLES, err is set (sticky until init). The FSM keeps waiting and never abandons a wavefront.
- Simultaneous events: acceptance into the buffer in the same cycle as the NULL_W to IDLE transition is legal, and that token is issued next.
- Mismatched completions (only one of ACOMP/steerinCOMP high) count as neither ack; the FSM holds.

Decomposition:
- Shared package ncl_steer_pkg:
  - state enum {IDLE, DATA, NULL_W}.
  - dual-rail constants DR_NULL=2'b00, DR_FALSE=2'b01, DR_TRUE=2'b10.
  - destination indices S=0, T=1, U=2, V=3.
- Sub-module ncl_comp_sync: parameterised SYNC_STAGES flop chain with async init clear. Instantiated twice, once for ACOMP and once for steerinCOMP.

Test Plan:
- Basic transfer: init pulse, then in_valid=1, in_sel=2, in_bit=1 -> next cycle A=10, steerin=0100. Raise both completions -> A=00, steerin=0000 within SYNC_STAGES+1 cycles. Drop both -> xfer_count=1, busy=0.
- Back-to-back: tokens (0,0),(3,1),(1,0) with in_valid held -> second token accepted into the buffer, in_ready=0 while the buffer is full. Observed outputs are A=01/steerin=0001, then A=10/steerin=1000, then A=01/steerin=0010, each separated by NULL. xfer_count ends at 3.
- Partial ack: ACOMP=1, steerinCOMP=0 in DATA -> outputs hold DATA, no transition. Then raise steerinCOMP -> NULL driven.
- Timeout: TIMEOUT_CYCLES=16, never raise completions -> err=1 after 16 cycles in DATA. Outputs stay A=10 (or 01), steerin unchanged. Later ack completes normally and err stays 1.
- Reset mid-op: assert init while in DATA -> A=00, steerin=0000, in_ready=1, err=0, xfer_count=0 without a clock edge.
- Counter wrap: CNT_W=2, five transfers -> xfer_count sequence 1,2,3,0,1.
